morse_char_sequencer: RTL and testbench

//  Sequences one letter at a time onto a single Morse LED output with standard unit timing:
//  dot 1 unit, dash 3, intra-letter gap 1, letter gap 3, word gap 7.

---
 rtl/morse_pkg.sv | 33 +++
 rtl/morse_unit_timer.sv | 29 ++
 rtl/morse_char_sequencer.sv | 129 ++++++++++++
 tb/tb_morse_char_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse character sequencer: FSM states, unit
// durations and the A..Z symbol tables (pattern MSB first, 1 = dash).
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_SGAP,
    ST_LGAP,
    ST_WGAP
  } state_t;

  localparam logic [2:0] DOT_U  = 3'd1;
  localparam logic [2:0] DASH_U = 3'd3;
  localparam logic [2:0] SGAP_U = 3'd1;
  localparam logic [2:0] LGAP_U = 3'd3;
  localparam logic [2:0] WGAP_U = 3'd7;

  localparam logic [4:0] CODE_MAX = 5'd25;

  // Index 0 is the leftmost entry, so the tables read A..Z left to right.
  localparam logic [0:25][2:0] MORSE_LEN = {
    3'd2, 3'd4, 3'd4, 3'd3, 3'd1, 3'd4, 3'd3, 3'd4, 3'd2, 3'd4, 3'd3, 3'd4, 3'd2,
    3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd3, 3'd1, 3'd3, 3'd4, 3'd3, 3'd4, 3'd4, 3'd4
  };

  localparam logic [0:25][3:0] MORSE_PAT = {
    4'b0100, 4'b1000, 4'b1010, 4'b1000, 4'b0000, 4'b0010, 4'b1100, 4'b0000, 4'b0000,
    4'b0111, 4'b1010, 4'b0100, 4'b1100, 4'b1000, 4'b1110, 4'b0110, 4'b1101, 4'b0100,
    4'b0000, 4'b1000, 4'b0010, 4'b0001, 4'b0110, 4'b1001, 4'b1011, 4'b1100
  };

endpackage

// File: rtl/morse_unit_timer.sv
// Unit prescaler: counts 0..UNIT_CYCLES-1 while run is high and pulses tick
// on the last count, wrapping straight back to 0 so phases abut exactly.
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 12_500_000,
  localparam int PRE_W = $clog2(UNIT_CYCLES)
) (
  input  logic CLOCK,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam logic [PRE_W-1:0] LAST = PRE_W'(UNIT_CYCLES - 1);
  localparam logic [PRE_W-1:0] ONE  = {{(PRE_W-1){1'b0}}, 1'b1};

  logic [PRE_W-1:0] r_count;

  assign tick = run & (r_count == LAST);

  always_ff @(posedge CLOCK) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (run) begin
      r_count <= tick ? '0 : r_count + ONE;
    end
  end

endmodule

// File: rtl/morse_char_sequencer.sv
// Plays one accepted letter (or word space) on the LED using Morse unit
// timing, then pulses done and returns to idle ready for the next code.
module morse_char_sequencer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12_500_000
) (
  input  logic       CLOCK,
  input  logic       reset,
  input  logic       en,
  input  logic       char_valid,
  input  logic [4:0] char_code,
  output logic       char_ready,
  output logic       busy,
  output logic       done,
  output logic       LED
);

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_idx;
  logic [3:0] r_pat;
  logic [2:0] r_units;
  logic       r_led;
  logic       r_done;

  logic       w_tick;
  logic       w_load;
  logic       w_shift;
  logic       w_phase_end;
  logic       w_done_next;
  logic       w_code_ok;
  logic [2:0] w_target;

  assign char_ready = (r_state == ST_IDLE) & en;
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign LED        = r_led;
  assign w_code_ok  = (char_code <= CODE_MAX);

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .CLOCK(CLOCK),
    .reset(reset),
    .clr  (w_load | ~en),
    .run  (busy),
    .tick (w_tick)
  );

  always_comb begin
    w_target = DOT_U;
    case (r_state)
      ST_MARK: w_target = r_pat[3] ? DASH_U : DOT_U;
      ST_SGAP: w_target = SGAP_U;
      ST_LGAP: w_target = LGAP_U;
      ST_WGAP: w_target = WGAP_U;
      default: w_target = DOT_U;
    endcase
  end

  assign w_phase_end = w_tick && (r_units == w_target - 3'd1);

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_done_next  = 1'b0;
    if (!en) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (char_valid) begin
            w_load       = 1'b1;
            w_state_next = w_code_ok ? ST_MARK : ST_WGAP;
          end
        end
        ST_MARK: begin
          if (w_phase_end) begin
            w_state_next = (r_idx == 3'd1) ? ST_LGAP : ST_SGAP;
          end
        end
        ST_SGAP: begin
          if (w_phase_end) begin
            w_state_next = ST_MARK;
            w_shift      = 1'b1;
          end
        end
        ST_LGAP, ST_WGAP: begin
          if (w_phase_end) begin
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_pat   <= '0;
      r_units <= '0;
      r_led   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_led   <= (w_state_next == ST_MARK);
      r_done  <= w_done_next;
      // Every phase starts its unit count from zero, including aborts.
      if (w_load || (w_state_next != r_state)) begin
        r_units <= '0;
      end else if (w_tick) begin
        r_units <= r_units + 3'd1;
      end
      if (w_load) begin
        r_idx <= w_code_ok ? MORSE_LEN[char_code] : 3'd0;
        r_pat <= w_code_ok ? MORSE_PAT[char_code] : 4'd0;
      end else if (w_shift) begin
        r_idx <= r_idx - 3'd1;
        r_pat <= {r_pat[2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_morse_char_sequencer.sv
// Scoreboard bench: stimulus pushes the expected LED waveform per character,
// a monitor captures LED/busy from accept to done and compares.
module tb_morse_char_sequencer;

  localparam int U = 4;

  logic       CLOCK = 1'b0;
  logic       reset;
  logic       en;
  logic       char_valid;
  logic [4:0] char_code;
  logic       char_ready;
  logic       busy;
  logic       done;
  logic       LED;

  int errors = 0;
  int checks = 0;

  always #5 CLOCK = ~CLOCK;

  morse_char_sequencer #(
    .UNIT_CYCLES(U)
  ) dut (
    .CLOCK     (CLOCK),
    .reset     (reset),
    .en        (en),
    .char_valid(char_valid),
    .char_code (char_code),
    .char_ready(char_ready),
    .busy      (busy),
    .done      (done),
    .LED       (LED)
  );

  string MORSE [26] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--.."
  };

  typedef struct packed {
    logic [127:0] led;
    logic [7:0]   len;
    logic [4:0]   code;
    logic         aborted;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Expected LED per cycle after accept: marks and gaps in whole units.
  function automatic exp_t model(input int code, input bit ab);
    exp_t  e;
    int    pos;
    int    m;
    int    g;
    byte   ch;
    string s;
    e = '0;
    e.code = code[4:0];
    e.aborted = ab;
    pos = 0;
    if (code > 25) begin
      pos = 7 * U;
    end else begin
      s = MORSE[code];
      for (int i = 0; i < s.len(); i++) begin
        ch = s[i];
        m = (ch == "-") ? 3 : 1;
        for (int c = 0; c < m * U; c++) begin
          e.led[pos] = 1'b1;
          pos++;
        end
        g = (i == s.len() - 1) ? 3 : 1;
        pos += g * U;
      end
    end
    e.len = pos[7:0];
    return e;
  endfunction

  // Monitor
  bit           active = 0;
  int           cyc = 0;
  logic [127:0] cap = '0;
  bit           busy_ok = 1;
  exp_t         m_e;

  always @(negedge CLOCK) begin
    if (active) begin
      cyc++;
      if (done) begin
        active = 0;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_without_expect cycle=%0d", cyc);
        end else begin
          m_e = exp_q.pop_front();
          if (m_e.aborted) begin
            checks++; errors++;
            $display("FAIL done_on_aborted code=%0d", m_e.code);
          end
          chk($sformatf("duration_code%0d", m_e.code), cyc, int'(m_e.len) + 1);
          checks++;
          if (cap !== m_e.led) begin
            errors++;
            $display("FAIL led_wave code=%0d actual=%h required=%h", m_e.code, cap, m_e.led);
          end
          chk($sformatf("busy_during_code%0d", m_e.code), busy_ok, 1);
          chk($sformatf("busy_at_done_code%0d", m_e.code), busy, 0);
          $display("char code=%0d done after %0d cycles", m_e.code, cyc);
        end
      end else if (reset || !en) begin
        active = 0;
        if (exp_q.size() != 0) begin
          m_e = exp_q.pop_front();
          if (!m_e.aborted) begin
            checks++; errors++;
            $display("FAIL unplanned_abort code=%0d", m_e.code);
          end else begin
            $display("char code=%0d aborted at cycle %0d", m_e.code, cyc);
          end
        end
      end else begin
        if (cyc <= 128) cap[cyc-1] = LED;
        if (!busy) busy_ok = 0;
        chk("ready_while_busy", char_ready, 0);
        if (cyc > 200) begin
          checks++; errors++;
          $display("FAIL done_timeout cycle=%0d", cyc);
          active = 0;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end
    end else if (done) begin
      checks++; errors++;
      $display("FAIL spurious_done actual=1 required=0");
    end
    if (!reset && en && char_valid && char_ready) begin
      active = 1;
      cyc = 0;
      cap = '0;
      busy_ok = 1;
    end
  end

  // Hold char_valid until accepted; optionally pulse junk while busy.
  task automatic send(input int code, input bit ab, input bit junk);
    int n;
    n = 0;
    char_code = code[4:0];
    char_valid = 1'b1;
    @(negedge CLOCK);
    while (!char_ready && n < 300) begin
      @(negedge CLOCK);
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL accept_timeout code=%0d", code);
    end else begin
      exp_q.push_back(model(code, ab));
    end
    @(posedge CLOCK); #1;
    char_valid = 1'b0;
    if (junk) begin
      for (int k = 0; k < 3; k++) begin
        char_valid = 1'($urandom_range(0, 1));
        char_code = 5'($urandom_range(0, 31));
        @(posedge CLOCK); #1;
      end
      char_valid = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b1;
    char_valid = 1'b0;
    char_code = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLOCK); #1;
      chk("reset_led", LED, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_ready", char_ready, 1);
    end
    reset = 1'b0;
    @(posedge CLOCK); #1;
    chk("idle_busy", busy, 0);
    chk("idle_ready", char_ready, 1);

    send(4, 0, 1);
    send(0, 0, 1);
    send(7, 0, 0);
    send(27, 0, 1);

    // Back-to-back: valid stays high, T taken on E's done cycle.
    send(4, 0, 0);
    send(19, 0, 0);
    repeat (60) @(posedge CLOCK);
    #1;

    // Abort via en at cycle 6 of a dash.
    send(19, 1, 0);
    repeat (5) @(posedge CLOCK);
    #1;
    chk("abort_led_before", LED, 1);
    en = 1'b0;
    @(posedge CLOCK); #1;
    chk("abort_led", LED, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready_en_low", char_ready, 0);
    char_valid = 1'b1;
    char_code = 5'd4;
    repeat (10) @(posedge CLOCK);
    #1;
    chk("en_low_no_accept", busy, 0);
    char_valid = 1'b0;
    en = 1'b1;

    // Reset mid-letter.
    send(0, 1, 0);
    repeat (9) @(posedge CLOCK);
    #1;
    reset = 1'b1;
    @(posedge CLOCK); #1;
    chk("rst_mid_led", LED, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    reset = 1'b0;

    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge CLOCK);
      #1;
      send(int'($urandom_range(0, 31)), 0, 1'($urandom_range(0, 1)));
    end

    for (int n = 0; n < 500 && (exp_q.size() != 0 || active); n++) begin
      @(posedge CLOCK);
    end
    #1;
    chk("drain_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
